// File: rtl/fixed3_norm_seq.sv
// fixed3_norm_seq: multi-cycle Q16.16 3-vector normaliser (v/|v|) with strobe/valid handshake.
// Optional NORM_LEN_OUT_EN adds len_out carrying the Q16.16 vector length.
module fixed3_norm_seq #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe,
    input  logic [3*WIDTH-1:0] v,
    output logic [3*WIDTH-1:0] ov,
    output logic               valid
`ifdef NORM_LEN_OUT_EN
    ,
    output logic [WIDTH:0]     len_out
`endif
);
    localparam int LW = 2*WIDTH+2;
    localparam int RW = WIDTH+1;
    localparam int QW = FRAC_BITS+1;
    localparam logic [QW-1:0] ONE = {1'b1, {FRAC_BITS{1'b0}}};
    typedef enum logic [2:0] {IDLE, SQ, SQRT, DIV, DONE} state_t;
    state_t state, state_n;
    logic [7:0]             cnt;
    logic [2:0][WIDTH-1:0]  mag, cmag, res;
    logic [2:0]             sgn, csgn, d_ge;
    logic [LW-1:0]          rad;
    logic [RW:0]            srem;
    logic [RW-1:0]          root;
    logic [RW+2:0]          s_t, s_trial;
    logic                   s_ge;
    logic [2:0][RW-1:0]     drem;
    logic [2:0][RW:0]       d_t;
    logic [2:0][QW-1:0]     qr, qc;
    // one restoring square-root step: two radicand bits in, one root bit out
    assign s_t     = {srem, rad[LW-1 -: 2]};
    assign s_trial = {2'b00, root, 2'b01};
    assign s_ge    = s_t >= s_trial;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            csgn[i] = v[i*WIDTH+WIDTH-1];
            cmag[i] = csgn[i] ? -v[i*WIDTH +: WIDTH] : v[i*WIDTH +: WIDTH];
            d_t[i]  = {drem[i], qr[i][QW-1]};
            d_ge[i] = d_t[i] >= {1'b0, root};
            qc[i]   = qr[i] > ONE ? ONE : qr[i];
            res[i]  = root == '0 ? '0 : (sgn[i] ? -WIDTH'(qc[i]) : WIDTH'(qc[i]));
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = strobe ? SQ : IDLE;
            SQ:      state_n = SQRT;
            SQRT:    state_n = cnt == 8'(RW-1) ? DIV : SQRT;
            DIV:     state_n = cnt == 8'(QW-1) ? DONE : DIV;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            mag   <= '0;
            sgn   <= '0;
            rad   <= '0;
            srem  <= '0;
            root  <= '0;
            drem  <= '0;
            qr    <= '0;
            ov    <= '0;
            valid <= 1'b0;
`ifdef NORM_LEN_OUT_EN
            len_out <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (strobe) begin
                    mag <= cmag;
                    sgn <= csgn;
                end
                SQ: begin
                    rad  <= LW'(mag[0])*LW'(mag[0]) + LW'(mag[1])*LW'(mag[1]) + LW'(mag[2])*LW'(mag[2]);
                    srem <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                SQRT: begin
                    rad  <= rad << 2;
                    srem <= (RW+1)'(s_ge ? s_t - s_trial : s_t);
                    root <= {root[RW-2:0], s_ge};
                    cnt  <= cnt == 8'(RW-1) ? '0 : cnt + 8'd1;
                    // dividend is |c| << FRAC_BITS; its top part seeds the remainder
                    for (int i = 0; i < 3; i++) begin
                        drem[i] <= RW'(mag[i] >> 1);
                        qr[i]   <= {mag[i][0], {FRAC_BITS{1'b0}}};
                    end
                end
                DIV: begin
                    for (int i = 0; i < 3; i++) begin
                        drem[i] <= d_ge[i] ? RW'(d_t[i] - {1'b0, root}) : RW'(d_t[i]);
                        qr[i]   <= {qr[i][QW-2:0], d_ge[i]};
                    end
                    cnt <= cnt + 8'd1;
                end
                DONE: begin
                    ov    <= res;
                    valid <= 1'b1;
`ifdef NORM_LEN_OUT_EN
                    len_out <= root;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed3_norm_seq.sv
// tb_fixed3_norm_seq: scoreboard bench for fixed3_norm_seq against an arithmetic reference model.
module tb_fixed3_norm_seq;
    logic        clk = 1'b0, reset = 1'b1, strobe = 1'b0;
    logic [95:0] v = '0;
    logic [95:0] ov;
    logic        valid;
`ifdef NORM_LEN_OUT_EN
    logic [32:0] len_out;
`endif
    typedef struct {
        logic [95:0] ov;
        logic [32:0] len;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t me;
    bit   mbad;
    int   tests = 0, fails = 0, cyc = 0;

    fixed3_norm_seq dut (
        .clk(clk), .reset(reset), .strobe(strobe), .v(v), .ov(ov), .valid(valid)
`ifdef NORM_LEN_OUT_EN
        , .len_out(len_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int x, int y, int z);
        exp_t e;
        int c[3];
        longint m, q;
        logic [67:0] l2;
        logic [32:0] len, cand;
        c = '{x, y, z};
        l2 = '0;
        len = '0;
        for (int i = 0; i < 3; i++) begin
            m = c[i] < 0 ? -longint'(c[i]) : longint'(c[i]);
            l2 += 68'(m) * 68'(m);
        end
        for (int b = 32; b >= 0; b--) begin
            cand = len | (33'd1 << b);
            if (68'(cand) * 68'(cand) <= l2) len = cand;
        end
        e.ov = '0;
        for (int i = 0; i < 3; i++) begin
            m = c[i] < 0 ? -longint'(c[i]) : longint'(c[i]);
            q = len == 0 ? 64'sd0 : (m << 16) / longint'(len);
            if (q > 65536) q = 65536;
            e.ov[i*32 +: 32] = 32'(c[i] < 0 ? -q : q);
        end
        e.len = len;
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid cyc=%0d ov=%h", cyc, ov);
            end else begin
                me = sb.pop_front();
                mbad = ov !== me.ov || cyc !== me.cyc;
`ifdef NORM_LEN_OUT_EN
                mbad = mbad || len_out !== me.len;
                if (mbad) $display("FAIL result ov=%h len=%0d cyc=%0d expected ov=%h len=%0d cyc=%0d",
                                   ov, len_out, cyc, me.ov, me.len, me.cyc);
`else
                if (mbad) $display("FAIL result ov=%h cyc=%0d expected ov=%h cyc=%0d", ov, cyc, me.ov, me.cyc);
`endif
                if (mbad) fails++;
            end
        end
    end

    task automatic run_op(int x, int y, int z, bit noise);
        exp_t e;
        @(negedge clk);
        v = {z, y, x};
        strobe = 1'b1;
        @(posedge clk);
        #1;
        e = model(x, y, z);
        e.cyc = cyc + 52;
        sb.push_back(e);
        repeat (52) begin
            @(negedge clk);
            strobe = noise ? 1'($urandom) : 1'b0;
            if (noise) v = {$urandom, $urandom, $urandom};
        end
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic check_idle(string name);
        tests++;
        if (ov !== '0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL %s ov=%h valid=%b expected ov=0 valid=0", name, ov, valid);
        end
    endtask

    initial begin
        exp_t e;
        int w;
        @(negedge clk);
        check_idle("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_op(196608, 262144, 0, 1'b0);
        run_op(0, -327680, 0, 1'b0);
        run_op(65536, 65536, 65536, 1'b0);
        run_op(0, 0, 0, 1'b0);
        run_op(int'(32'h80000000), int'(32'h80000000), int'(32'h80000000), 1'b0);
        run_op(int'(32'h7fffffff), 0, 0, 1'b0);
        run_op(0, 0, int'(32'h80000000), 1'b0);
        run_op(1, 0, 0, 1'b0);
        run_op(-1, 1, -1, 1'b0);
        run_op(3, -65536*700, 12345, 1'b1);
        for (int k = 0; k < 24; k++)
            run_op(int'($urandom) >>> $urandom_range(0, 31), int'($urandom) >>> $urandom_range(0, 31),
                   int'($urandom) >>> $urandom_range(0, 31), k[0]);
        // strobe held high: one accept every 53 edges
        @(negedge clk);
        v = {32'sd0, -32'sd131072, 32'sd65536};
        strobe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            e = model(65536, -131072, 0);
            e.cyc = cyc + 52;
            sb.push_back(e);
            if (k < 2) repeat (52) @(posedge clk);
        end
        @(negedge clk);
        strobe = 1'b0;
        repeat (53) @(posedge clk);
        // reset 20 cycles into an operation abandons it
        @(negedge clk);
        v = {32'sd7, 32'sd9, -32'sd11};
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("mid_op_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_op(196608, 262144, 0, 1'b0);
        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        repeat (60) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
